// File: rtl/rvv_backend_alu_unit_viota_prefix_pkg.sv
// Shared constants and types for the viota/vcpop prefix-popcount engine
// and the ALU p1 stage that consumes its per-64-bit-chunk counts.
package rvv_backend_alu_unit_viota_prefix_pkg;

   localparam int VIOTA_VLEN    = 128;
   localparam int VIOTA_CHUNK_W = 64;
   localparam int VIOTA_SLICE_W = 16;
   localparam int VIOTA_TAG_W   = 32;
   localparam int VIOTA_CNT_W   = $clog2(VIOTA_CHUNK_W) + 1;

   typedef logic [VIOTA_CNT_W-1:0] viota_cnt_t;

   // Same layout as PIPE_DATA_t.data_viota_per64: [chunk][bit][count]
   typedef logic [VIOTA_VLEN/VIOTA_CHUNK_W-1:0][VIOTA_CHUNK_W-1:0][VIOTA_CNT_W-1:0] viota_per64_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } VIOTA_STATE_e;

endpackage

// File: rtl/rvv_backend_alu_slice_prefix.sv
// Combinational inclusive prefix popcount of one slice, offset by the
// running sum of the slices already processed in the same chunk.
module rvv_backend_alu_slice_prefix
   import rvv_backend_alu_unit_viota_prefix_pkg::*;
#(
   parameter int SLICE_W = VIOTA_SLICE_W,
   parameter int CNT_W   = VIOTA_CNT_W
) (
   input  logic [SLICE_W-1:0]            i_slice,
   input  logic [CNT_W-1:0]              i_base,
   output logic [SLICE_W-1:0][CNT_W-1:0] o_prefix,
   output logic [CNT_W-1:0]              o_popcnt
);

   logic [CNT_W-1:0] w_local;

   always_comb begin
      w_local  = '0;
      o_prefix = '0;
      for (int k = 0; k < SLICE_W; k++) begin
         w_local     = w_local + CNT_W'(i_slice[k]);
         o_prefix[k] = i_base + w_local;
      end
      o_popcnt = w_local;
   end

endmodule

// File: rtl/rvv_backend_alu_unit_viota_prefix.sv
// Multi-cycle per-chunk prefix popcount feeding data_viota_per64 of ALU p1.
// Each chunk walks its slices in parallel; the accept cycle computes slice 0.
module rvv_backend_alu_unit_viota_prefix
   import rvv_backend_alu_unit_viota_prefix_pkg::*;
#(
   parameter int VLEN    = VIOTA_VLEN,
   parameter int CHUNK_W = VIOTA_CHUNK_W,
   parameter int SLICE_W = VIOTA_SLICE_W,
   parameter int TAG_W   = VIOTA_TAG_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [VLEN-1:0]      in_mask,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [TAG_W-1:0]     out_tag,
   output logic [(VLEN/CHUNK_W)*CHUNK_W*($clog2(CHUNK_W)+1)-1:0] out_viota_per64
);

   localparam int NCH   = VLEN / CHUNK_W;
   localparam int NSL   = CHUNK_W / SLICE_W;
   localparam int CNT_W = $clog2(CHUNK_W) + 1;
   localparam int SL_CW = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [SL_CW-1:0] LAST_SL = SL_CW'(NSL - 1);

   VIOTA_STATE_e     r_state;
   logic             r_out_valid;
   logic [TAG_W-1:0] r_tag;
   logic [VLEN-1:0]  r_mask;
   logic [SL_CW-1:0] r_slice;

   logic             w_accept;
   logic             w_calc;
   logic [SL_CW-1:0] w_sel_slice;
   logic             w_last;

   assign in_ready    = ~flush & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
   assign w_accept    = in_valid & in_ready;
   assign w_calc      = ~flush & (r_state == CALC);
   assign w_sel_slice = w_accept ? '0 : r_slice;
   assign w_last      = (w_sel_slice == LAST_SL);

   assign out_valid = r_out_valid;
   assign out_tag   = r_tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_tag       <= '0;
         r_mask      <= '0;
         r_slice     <= '0;
      end else if (flush) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_slice     <= '0;
      end else if (w_accept) begin
         r_tag       <= in_tag;
         r_mask      <= in_mask;
         r_state     <= w_last ? DONE : CALC;
         r_out_valid <= w_last;
         r_slice     <= w_last ? '0 : SL_CW'(1);
      end else begin
         case (r_state)
            CALC: begin
               if (w_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_slice     <= '0;
               end else begin
                  r_slice <= r_slice + SL_CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chunk
         logic [CHUNK_W-1:0]              w_chunk;
         logic [SLICE_W-1:0]              w_slice;
         logic [CNT_W-1:0]                w_base;
         logic [CNT_W-1:0]                w_pop;
         logic [SLICE_W-1:0][CNT_W-1:0]   w_prefix;
         logic [CHUNK_W-1:0][CNT_W-1:0]   r_viota;
         logic [CNT_W-1:0]                r_sum;

         // Slice 0 is taken straight from the input so the accept cycle does useful work
         assign w_chunk = w_accept ? in_mask[gi*CHUNK_W +: CHUNK_W] : r_mask[gi*CHUNK_W +: CHUNK_W];
         assign w_base  = w_accept ? '0 : r_sum;

         always_comb begin
            w_slice = '0;
            for (int s = 0; s < NSL; s++) begin
               if (SL_CW'(s) == w_sel_slice) begin
                  w_slice = w_chunk[s*SLICE_W +: SLICE_W];
               end
            end
         end

         rvv_backend_alu_slice_prefix #(
            .SLICE_W (SLICE_W),
            .CNT_W   (CNT_W)
         ) u_slice_prefix (
            .i_slice  (w_slice),
            .i_base   (w_base),
            .o_prefix (w_prefix),
            .o_popcnt (w_pop)
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sum   <= '0;
               r_viota <= '0;
            end else if (w_accept | w_calc) begin
               r_sum <= w_base + w_pop;
               for (int j = 0; j < CHUNK_W; j++) begin
                  if (SL_CW'(j / SLICE_W) == w_sel_slice) begin
                     r_viota[j] <= w_prefix[j % SLICE_W];
                  end
               end
            end
         end

         assign out_viota_per64[gi*CHUNK_W*CNT_W +: CHUNK_W*CNT_W] = r_viota;
      end
   endgenerate

endmodule

// File: tb/tb_rvv_backend_alu_unit_viota_prefix.sv
// Directed bench for the viota prefix engine: a queue-based reference model
// checked every cycle out_valid is high, plus literal spot checks.
module tb_rvv_backend_alu_unit_viota_prefix;

   localparam int VLEN = 128;
   localparam int CW   = 64;
   localparam int NW   = 7;
   localparam int TW   = 32;
   localparam int OUTW = (VLEN / CW) * CW * NW;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [VLEN-1:0] in_mask;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [TW-1:0]   out_tag;
   logic [OUTW-1:0] out_viota_per64;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [VLEN-1:0] mask;
      logic [TW-1:0]   tag;
      int              acc;
   } item_t;

   item_t q[$];
   bit    seen = 1'b0;
   int    last_first = -1;

   rvv_backend_alu_unit_viota_prefix dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_mask         (in_mask),
      .in_tag          (in_tag),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_tag         (out_tag),
      .out_viota_per64 (out_viota_per64)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Count of ones at or below each position within each 64-bit chunk
   function automatic int expect_cnt(input logic [VLEN-1:0] m, input int c, input int j);
      int n = 0;
      for (int b = 0; b <= j; b++) n += int'(m[c*CW + b]);
      return n;
   endfunction

   function automatic int fld(input logic [OUTW-1:0] v, input int c, input int j);
      return int'(v[(c*CW + j)*NW +: NW]);
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Compare process: every cycle a result is presented
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 tag=%h, expected none pending", out_tag);
         end else begin
            int bad_c = -1;
            int bad_j = -1;
            for (int c = 0; c < VLEN/CW; c++)
               for (int j = 0; j < CW; j++)
                  if (bad_c < 0 && fld(out_viota_per64, c, j) != expect_cnt(q[0].mask, c, j)) begin
                     bad_c = c;
                     bad_j = j;
                  end
            if (bad_c >= 0) begin
               errors++;
               $display("FAIL viota tag=%h chunk=%0d elem=%0d: got %0d, expected %0d", q[0].tag, bad_c, bad_j,
                        fld(out_viota_per64, bad_c, bad_j), expect_cnt(q[0].mask, bad_c, bad_j));
            end
            checks++;
            if (out_tag !== q[0].tag) begin
               errors++;
               $display("FAIL out_tag: got %h, expected %h", out_tag, q[0].tag);
            end
            if (!seen) begin
               seen = 1'b1;
               last_first = cyc;
               checks++;
               if (cyc != q[0].acc + 4) begin
                  errors++;
                  $display("FAIL latency tag=%h: got cycle %0d, expected %0d", q[0].tag, cyc, q[0].acc + 4);
               end
            end
            if (out_ready) begin
               $display("result tag=%h mask=%h delivered cycle %0d", q[0].tag, q[0].mask, cyc);
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [VLEN-1:0] m, input logic [TW-1:0] t, output int acc);
      bit got = 1'b0;
      acc      = -1;
      in_mask  = m;
      in_tag   = t;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            acc = cyc;
            q.push_back('{m, t, cyc});
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout tag=%h: got in_ready=0 for 40 cycles, expected acceptance", t);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got out_valid=0 for 30 cycles, expected 1", nm);
      end
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: got %0d results pending, expected 0", nm, q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, pf, fcyc;
      logic [VLEN-1:0] m;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_mask   = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_tag", int'(out_tag), 0);
      chk("reset_viota_zero", int'(out_viota_per64 == '0), 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // All-zero mask
      send('0, 32'h0000_0011, a0);
      wait_valid("zero");
      chk("zero_c1_e63", fld(out_viota_per64, 1, 63), 0);
      chk("zero_tag", int'(out_tag), 32'h11);
      drain("zero");

      // All-one mask
      send('1, 32'h0000_0022, a0);
      wait_valid("ones");
      chk("ones_c0_e0", fld(out_viota_per64, 0, 0), 1);
      chk("ones_c0_e63", fld(out_viota_per64, 0, 63), 64);
      chk("ones_c1_e31", fld(out_viota_per64, 1, 31), 32);
      chk("ones_c1_e63", fld(out_viota_per64, 1, 63), 64);
      drain("ones");

      // Lowest bit of chunk 0 and highest bit of chunk 1
      m = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
      send(m, 32'h0000_0033, a0);
      wait_valid("edge");
      chk("edge_c0_e0", fld(out_viota_per64, 0, 0), 1);
      chk("edge_c0_e63", fld(out_viota_per64, 0, 63), 1);
      chk("edge_c1_e62", fld(out_viota_per64, 1, 62), 0);
      chk("edge_c1_e63", fld(out_viota_per64, 1, 63), 1);
      drain("edge");

      // Back-to-back with zero bubble
      send(128'haaaaaaaa_aaaaaaaa_55555555_55555555, 32'h0000_0044, a0);
      send(128'h01234567_89abcdef_fedcba98_76543210, 32'h0000_0055, a1);
      chk("b2b_accept_in_done", a1, last_first);
      drain("b2b");

      // Backpressure for three DONE cycles, then handoff
      out_ready = 1'b0;
      send(128'h0f0f0f0f_0f0f0f0f_ffff0000_0000ffff, 32'h0000_0066, a0);
      wait_valid("bp");
      pf = cyc;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_out_tag", int'(out_tag), 32'h66);
         if (i < 2) @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(128'h00000000_00000001_80000000_00000000, 32'h0000_0077, a1);
      chk("bp_handoff_cycle", a1, pf + 3);
      @(negedge clk);
      chk("bp_valid_drops", int'(out_valid), 0);
      drain("bp");

      // Flush in the second CALC cycle
      send('1, 32'h0000_0088, a0);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", int'(in_ready), 0);
      fcyc = cyc;
      @(posedge clk);
      #1;
      flush = 1'b0;
      q.delete();
      seen = 1'b0;
      send(128'hdeadbeef_cafef00d_12345678_9abcdef0, 32'h0000_0099, a1);
      chk("flush_next_accept", a1, fcyc + 1);
      drain("flush");

      // Flush wins over a same-cycle request while idle
      in_mask  = '1;
      in_tag   = 32'h0000_00aa;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      chk("flush_idle_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("flush_idle_no_result", int'(out_valid), 0);

      // Asynchronous reset mid-CALC
      @(posedge clk);
      #1;
      send(128'hffffffff_00000000_ffffffff_00000000, 32'h0000_00bb, a0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("areset_out_valid", int'(out_valid), 0);
      chk("areset_out_tag", int'(out_tag), 0);
      chk("areset_viota_zero", int'(out_viota_per64 == '0), 1);
      chk("areset_in_ready", int'(in_ready), 1);
      q.delete();
      seen = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk);
      #1;
      send(128'h13579bdf_02468ace_fdb97531_eca86420, 32'h0000_00cc, a0);
      drain("recover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
